// File: rtl/pcie_snoop_fifo_arb_if.sv
// Snoop-source and FIFO write-side signals for pcie_snoop_fifo_arb.
// Handshake: a word moves on any cycle where sN_valid and sN_ready are both high; ready may depend combinationally on valid and full.
interface pcie_snoop_fifo_arb_if;
  logic [71:0] s0_din;
  logic        s0_valid;
  logic        s0_ready;
  logic [71:0] s1_din;
  logic        s1_valid;
  logic        s1_ready;
  logic [71:0] din;
  logic        wr_en;
  logic        full;

  modport slave (
    input  s0_din, s0_valid, s1_din, s1_valid, full,
    output s0_ready, s1_ready, din, wr_en
  );

  modport master (
    output s0_din, s0_valid, s1_din, s1_valid, full,
    input  s0_ready, s1_ready, din, wr_en
  );
endinterface

// File: rtl/pcie_snoop_fifo_arb.sv
// TLP-granular round-robin arbiter feeding the XGMII-TX snoop FIFO from two snoop sources.
// Define SNOOP_ARB_IFG_EN to append Gap inter-frame-gap words after every TLP.
module pcie_snoop_fifo_arb #(
  parameter logic [2:0] Gap       = 3'd3,
  parameter logic [9:0] MAX_WORDS = 10'd130
) (
  input  logic                        clk,
  input  logic                        sys_rst_n,
  pcie_snoop_fifo_arb_if.slave        bus,
  output logic [1:0]                  grant,
  output logic [15:0]                 pkt_cnt0,
  output logic [15:0]                 pkt_cnt1,
  output logic                        trunc_err,
  output logic [1:0]                  state_dbg
);

  localparam logic [71:0] IFG_WORD = {8'h10, 64'h0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef SNOOP_ARB_IFG_EN
    GAP  = 2'd2,
`endif
    XFER = 2'd1
  } state_t;

  state_t      state, state_n;
  logic [1:0]  grant_n;
  logic        rr, rr_n;          // index of the source served last
  logic [9:0]  wcnt, wcnt_n;
  logic [2:0]  gcnt, gcnt_n;
  logic [71:0] din_n;
  logic        wr_en_n;
  logic [15:0] pkt_cnt0_n, pkt_cnt1_n;
  logic        trunc_n;

  logic        sel;
  logic [71:0] word;
  logic        accept;
  logic        force_last;
  logic        tlp_end;

  assign bus.s0_ready = (state == XFER) & grant[0] & bus.s0_valid & ~bus.full;
  assign bus.s1_ready = (state == XFER) & grant[1] & bus.s1_valid & ~bus.full;

  assign sel        = grant[1];
  assign word       = sel ? bus.s1_din : bus.s0_din;
  assign accept     = bus.s0_ready | bus.s1_ready;
  assign force_last = accept & ~word[65] & (wcnt == MAX_WORDS - 10'd1);
  assign tlp_end    = accept & (word[65] | force_last);
  assign state_dbg  = state;

`ifndef SNOOP_ARB_IFG_EN
  logic unused_gap;
  assign unused_gap = ^Gap;
`endif

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    rr_n       = rr;
    wcnt_n     = wcnt;
    gcnt_n     = gcnt;
    din_n      = bus.din;
    wr_en_n    = 1'b0;
    pkt_cnt0_n = pkt_cnt0;
    pkt_cnt1_n = pkt_cnt1;
    trunc_n    = trunc_err;
    case (state)
      IDLE: begin
        if (bus.s0_valid || bus.s1_valid) begin
          state_n = XFER;
          wcnt_n  = 10'd0;
          if (bus.s0_valid && bus.s1_valid) grant_n = rr ? 2'b01 : 2'b10;
          else if (bus.s0_valid)            grant_n = 2'b01;
          else                              grant_n = 2'b10;
        end
      end
      XFER: begin
        if (accept) begin
          din_n     = word;
          din_n[64] = (wcnt == 10'd0);
          din_n[65] = word[65] | force_last;
          wr_en_n   = 1'b1;
          wcnt_n    = wcnt + 10'd1;
          if (force_last) trunc_n = 1'b1;
          if (tlp_end) begin
            if (sel) pkt_cnt1_n = pkt_cnt1 + 16'd1;
            else     pkt_cnt0_n = pkt_cnt0 + 16'd1;
            rr_n    = sel;
            grant_n = 2'b00;
`ifdef SNOOP_ARB_IFG_EN
            if (Gap != 3'd0) begin
              state_n = GAP;
              gcnt_n  = Gap;
            end else begin
              state_n = IDLE;
            end
`else
            state_n = IDLE;
`endif
          end
        end
      end
`ifdef SNOOP_ARB_IFG_EN
      GAP: begin
        // full freezes the countdown rather than dropping gap words
        if (!bus.full) begin
          din_n   = IFG_WORD;
          wr_en_n = 1'b1;
          gcnt_n  = gcnt - 3'd1;
          if (gcnt == 3'd1) state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      grant     <= 2'b00;
      rr        <= 1'b1;
      wcnt      <= 10'd0;
      gcnt      <= 3'd0;
      bus.din   <= 72'h0;
      bus.wr_en <= 1'b0;
      pkt_cnt0  <= 16'd0;
      pkt_cnt1  <= 16'd0;
      trunc_err <= 1'b0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      rr        <= rr_n;
      wcnt      <= wcnt_n;
      gcnt      <= gcnt_n;
      bus.din   <= din_n;
      bus.wr_en <= wr_en_n;
      pkt_cnt0  <= pkt_cnt0_n;
      pkt_cnt1  <= pkt_cnt1_n;
      trunc_err <= trunc_n;
    end
  end

endmodule

// File: tb/tb_pcie_snoop_fifo_arb.sv
// Directed bench for pcie_snoop_fifo_arb (MAX_WORDS=4, Gap=3); expected FIFO writes kept in exp_q.
module tb_pcie_snoop_fifo_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pcie_snoop_fifo_arb_if bus();
  logic [1:0]  grant;
  logic [1:0]  state_dbg;
  logic [15:0] pkt_cnt0, pkt_cnt1;
  logic        trunc_err;

  pcie_snoop_fifo_arb #(.Gap(3'd3), .MAX_WORDS(10'd4)) dut (
    .clk(clk),
    .sys_rst_n(rst_n),
    .bus(bus),
    .grant(grant),
    .pkt_cnt0(pkt_cnt0),
    .pkt_cnt1(pkt_cnt1),
    .trunc_err(trunc_err),
    .state_dbg(state_dbg)
  );

  localparam logic [71:0] IFG = {8'h10, 64'h0};

  int n_checks = 0;
  int n_errors = 0;
  logic [71:0] exp_q[$];
  logic [71:0] src0_q[$];
  logic [71:0] src1_q[$];

  function automatic logic [71:0] mk(input logic [2:0] tag, input logic [63:0] data,
                                     input logic st, input logic lst);
    return {tag, 1'b0, 2'b11, lst, st, data};
  endfunction

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_ifg();
`ifdef SNOOP_ARB_IFG_EN
    repeat (3) exp_q.push_back(IFG);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    bus.full = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // presents queued words from one source, holding valid until each is accepted
  task automatic run_src(input int s);
    logic [71:0] w;
    logic acc;
    int g;
    @(negedge clk);
    while ((s == 0 && src0_q.size() > 0) || (s == 1 && src1_q.size() > 0)) begin
      if (s == 0) begin w = src0_q.pop_front(); bus.s0_din = w; bus.s0_valid = 1'b1; end
      else        begin w = src1_q.pop_front(); bus.s1_din = w; bus.s1_valid = 1'b1; end
      acc = 1'b0;
      g = 0;
      while (!acc && g < 200) begin
        #1;
        acc = (s == 0) ? bus.s0_ready : bus.s1_ready;
        @(posedge clk);
        if (!acc) @(negedge clk);
        g++;
      end
      if (!acc) begin
        check("src_accept", {71'b0, acc}, 72'h1);
        if (s == 0) begin src0_q.delete(); bus.s0_valid = 1'b0; end
        else        begin src1_q.delete(); bus.s1_valid = 1'b0; end
        return;
      end
      @(negedge clk);
      check("accept_lat", {bus.wr_en, bus.din[63:0]}, {1'b1, w[63:0]});
    end
    if (s == 0) bus.s0_valid = 1'b0;
    else        bus.s1_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  // scoreboard: every FIFO write must be the next expected word
  initial begin
    forever begin
      @(negedge clk);
      if (bus.wr_en) begin
        if (exp_q.size() == 0) check("unexp_wr", {71'b0, bus.wr_en}, 72'h0);
        else                   check("wr_data", bus.din, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.s0_din = 72'h0; bus.s1_din = 72'h0;
    bus.s0_valid = 1'b1; bus.s1_valid = 1'b1;
    bus.full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_din", bus.din, 0);
    check("rst_cnt0", pkt_cnt0, 0);
    check("rst_cnt1", pkt_cnt1, 0);
    check("rst_trunc", trunc_err, 0);
    check("rst_ready", {bus.s0_ready, bus.s1_ready}, 0);
    check("rst_state", state_dbg, 0);
    bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // single 4-word TLP; input b64 is wrong on purpose to exercise forcing
    src0_q.push_back(mk(3'd1, 64'h11, 1'b0, 1'b0));
    src0_q.push_back(mk(3'd1, 64'h12, 1'b1, 1'b0));
    src0_q.push_back(mk(3'd1, 64'h13, 1'b0, 1'b0));
    src0_q.push_back(mk(3'd1, 64'h14, 1'b0, 1'b1));
    exp_q.push_back(mk(3'd1, 64'h11, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd1, 64'h12, 1'b0, 1'b0));
    exp_q.push_back(mk(3'd1, 64'h13, 1'b0, 1'b0));
    exp_q.push_back(mk(3'd1, 64'h14, 1'b0, 1'b1));
    push_ifg();
    run_src(0);
    drain("t1_drain");
    check("t1_cnt0", pkt_cnt0, 1);
    check("t1_cnt1", pkt_cnt1, 0);
    check("t1_grant", grant, 0);

    // both sources contending from reset: strict TLP alternation, source 0 first
    do_reset();
    src0_q.push_back(mk(3'd2, 64'h21, 1'b0, 1'b0));
    src0_q.push_back(mk(3'd2, 64'h22, 1'b0, 1'b1));
    src0_q.push_back(mk(3'd2, 64'h23, 1'b0, 1'b0));
    src0_q.push_back(mk(3'd2, 64'h24, 1'b0, 1'b1));
    src1_q.push_back(mk(3'd3, 64'h31, 1'b0, 1'b0));
    src1_q.push_back(mk(3'd3, 64'h32, 1'b0, 1'b1));
    src1_q.push_back(mk(3'd3, 64'h33, 1'b0, 1'b0));
    src1_q.push_back(mk(3'd3, 64'h34, 1'b0, 1'b1));
    exp_q.push_back(mk(3'd2, 64'h21, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd2, 64'h22, 1'b0, 1'b1));
    push_ifg();
    exp_q.push_back(mk(3'd3, 64'h31, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd3, 64'h32, 1'b0, 1'b1));
    push_ifg();
    exp_q.push_back(mk(3'd2, 64'h23, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd2, 64'h24, 1'b0, 1'b1));
    push_ifg();
    exp_q.push_back(mk(3'd3, 64'h33, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd3, 64'h34, 1'b0, 1'b1));
    push_ifg();
    fork
      run_src(0);
      run_src(1);
    join
    drain("t2_drain");
    check("t2_cnt0", pkt_cnt0, 2);
    check("t2_cnt1", pkt_cnt1, 2);

    // full held 5 cycles after the first word of a TLP
    src0_q.push_back(mk(3'd4, 64'h41, 1'b0, 1'b0));
    src0_q.push_back(mk(3'd4, 64'h42, 1'b0, 1'b0));
    src0_q.push_back(mk(3'd4, 64'h43, 1'b0, 1'b0));
    src0_q.push_back(mk(3'd4, 64'h44, 1'b0, 1'b1));
    exp_q.push_back(mk(3'd4, 64'h41, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd4, 64'h42, 1'b0, 1'b0));
    exp_q.push_back(mk(3'd4, 64'h43, 1'b0, 1'b0));
    exp_q.push_back(mk(3'd4, 64'h44, 1'b0, 1'b1));
    push_ifg();
    fork
      run_src(0);
      begin
        int wr_seen = 0;
        int rdy_seen = 0;
        repeat (3) @(negedge clk);
        bus.full = 1'b1;
        for (int i = 0; i < 5; i++) begin
          if (i > 0) begin
            @(negedge clk);
            if (bus.wr_en) wr_seen++;
          end
          #1;
          if (bus.s0_ready) rdy_seen++;
        end
        @(negedge clk);
        bus.full = 1'b0;
        check("stall_wr", wr_seen, 0);
        check("stall_rdy", rdy_seen, 0);
      end
    join
    drain("t3_drain");
    check("t3_cnt0", pkt_cnt0, 3);

    // truncation at 4 words; words 5-6 become a new TLP
    do_reset();
    check("t4_trunc_pre", trunc_err, 0);
    for (int i = 1; i <= 6; i++)
      src0_q.push_back(mk(3'd5, 64'h50 + 64'(i), 1'b0, (i == 6)));
    exp_q.push_back(mk(3'd5, 64'h51, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd5, 64'h52, 1'b0, 1'b0));
    exp_q.push_back(mk(3'd5, 64'h53, 1'b0, 1'b0));
    exp_q.push_back(mk(3'd5, 64'h54, 1'b0, 1'b1));
    push_ifg();
    exp_q.push_back(mk(3'd5, 64'h55, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd5, 64'h56, 1'b0, 1'b1));
    push_ifg();
    run_src(0);
    drain("t4_drain");
    check("t4_trunc", trunc_err, 1);
    check("t4_cnt0", pkt_cnt0, 2);

    // reset mid-TLP while word 2 is presented
    exp_q.push_back(mk(3'd6, 64'h61, 1'b1, 1'b0));
    @(negedge clk);
    bus.s0_din = mk(3'd6, 64'h61, 1'b0, 1'b0);
    bus.s0_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_pre_wr", {bus.wr_en, grant}, {1'b1, 2'b01});
    bus.s0_din = mk(3'd6, 64'h62, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_wr_en", bus.wr_en, 0);
    check("t5_din", bus.din, 0);
    check("t5_grant", grant, 0);
    check("t5_cnt0", pkt_cnt0, 0);
    check("t5_trunc", trunc_err, 0);
    check("t5_ready", bus.s0_ready, 0);
    bus.s0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    src0_q.push_back(mk(3'd7, 64'h71, 1'b0, 1'b0));
    src0_q.push_back(mk(3'd7, 64'h72, 1'b0, 1'b1));
    exp_q.push_back(mk(3'd7, 64'h71, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd7, 64'h72, 1'b0, 1'b1));
    push_ifg();
    run_src(0);
    drain("t5_drain");
    check("t5_cnt0_post", pkt_cnt0, 1);

    // back-to-back single-word TLPs; regrant timing depends on IFG build
    src0_q.push_back(mk(3'd0, 64'h81, 1'b0, 1'b1));
    src0_q.push_back(mk(3'd0, 64'h82, 1'b0, 1'b1));
    exp_q.push_back(mk(3'd0, 64'h81, 1'b1, 1'b1));
    push_ifg();
    exp_q.push_back(mk(3'd0, 64'h82, 1'b1, 1'b1));
    push_ifg();
    fork
      run_src(0);
      begin
        int g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!bus.wr_en && g < 50);
        @(negedge clk);
`ifdef SNOOP_ARB_IFG_EN
        check("t6_regrant", grant, 2'b00);
`else
        check("t6_regrant", grant, 2'b01);
`endif
      end
    join
    drain("t6_drain");
    check("t6_cnt0", pkt_cnt0, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pcie_snoop_fifo_arb.md
# pcie_snoop_fifo_arb

Packet-granular arbiter sharing the single XGMII-TX snoop FIFO write port between two PCIe snoop sources: the RX-side and TX-side TLP snoopers. It grants one source at a time, holds the grant for a whole TLP, and optionally pads each TLP with inter-frame-gap words. It sits between the snoop modules and the 72-bit FIFO feeding the XGMII transmitter.

## Interface
Parameters:
- Gap, 3'd3, number of IFG words inserted after each TLP; 0 disables padding even when compiled in
- MAX_WORDS, 10'd130, maximum words per TLP before forced truncation

Ports:
- clk  in  1  snoop/PCIe user clock; sole clock
- sys_rst_n  in  1  asynchronous, active-low reset
- s0_din  in  72  source 0 word: b63-0 data, b64 start, b65 last, b66/b67 dword enables, b68 IFG, b71-69 tag
- s0_valid  in  1  source 0 word valid
- s0_ready  out  1  source 0 word accepted this cycle
- s1_din / s1_valid / s1_ready  same as source 0, for source 1
- din  out  72  FIFO write data (registered)
- wr_en  out  1  FIFO write strobe (registered)
- full  in  1  FIFO programmable-full; must assert with ≥2 free entries
- grant  out  2  one-hot current owner; 2'b00 when idle
- pkt_cnt0, pkt_cnt1  out  16  completed TLPs per source, wrapping
- trunc_err  out  1  sticky: a TLP was truncated at MAX_WORDS

## Operation
- States: IDLE, XFER, GAP.
- IDLE: if exactly one source valid, grant it; if both valid, grant the source not served last (rr pointer; reset value makes source 0 win first tie). Grant registered; transfer begins the next cycle. No word accepted in IDLE.
- XFER: sN_ready = grant[N] & sN_valid & ~full (combinational). On accept, next edge: din <= sN_din, wr_en <= 1; otherwise wr_en <= 0. Non-granted ready is always 0.
- Word counter (10-bit) increments per accepted word, cleared on entering XFER. Accepted word with b65=1 ends the TLP. If the counter reaches MAX_WORDS-1 on an accept without b65, din b65 is forced to 1, trunc_err sets, and the TLP ends; remaining source words are treated as a new TLP.
- TLP end: pkt_cntN increments (wraps 16'hFFFF->0), rr pointer <= N, grant released; go to GAP if Gap≠0 and IFG is compiled in, else IDLE.
- GAP: writes IFG word {8'h10, 64'h0} once per cycle with ~full, down-counting Gap words; full stalls the count without writing. Then IDLE.
- b64 of the first word of each TLP is forced to 1; it is forced to 0 on all other words.

## Timing
- Reset values: din 72'h0, wr_en 0, grant 0, s0_ready/s1_ready 0, pkt_cnt0/1 0, trunc_err 0, state IDLE, rr pointer = source 1.
- Latency: accept to wr_en/din = 1 cycle. Valid in IDLE to first accept = 1 cycle minimum.
- full is sampled in the accept cycle; one write may land after full rises (hence the ≥2-entry margin).
- Source deasserting valid mid-TLP: grant held indefinitely, wr_en 0 meanwhile.
- Reset asserted mid-TLP: all outputs return to reset values immediately; any partial TLP is abandoned with no last word written.
- Single-word TLP (b65 on the first word): valid TLP; counter increments.

## Configuration
- SNOOP_ARB_IFG_EN defined: GAP state and IFG word insertion as above.
- Not defined: GAP state absent; TLP end returns directly to IDLE; Gap parameter ignored; no IFG words ever written.

## Test plan
- Source 0 only, 4-word TLP, full=0 -> four writes, one cycle after each accept, with b64 on word 1 and b65 on word 4, then 3 IFG words 72'h10_0000000000000000; pkt_cnt0=1.
- Both sources valid from reset, 2-word TLPs each -> source 0 served first, then source 1, alternating thereafter; a TLP's words are never interleaved with the other source.
- full raised for 5 cycles mid-TLP -> no accept and no wr_en during stall; at most one write after full rises; data is in order with no loss.
- MAX_WORDS=4, 6-word TLP without last -> 4th word written with b65 forced to 1; trunc_err=1; words 5-6 form a new TLP with b64=1.
- sys_rst_n pulled low on word 2 of a TLP -> wr_en, grant, and counters are 0 within the same cycle; a fresh TLP after release is handled normally.
- Build without SNOOP_ARB_IFG_EN, back-to-back TLPs -> no IFG words written; next grant one cycle after the last word.
